// File: rtl/led_fill_drain_pkg.sv
// Shared types and defaults for the LED fill/drain sequencer.
// Holds the FSM state encoding and the counter sizing helper.
package led_fill_drain_pkg;

  typedef enum logic [1:0] {
    FILL       = 2'd0,
    HOLD_FULL  = 2'd1,
    DRAIN      = 2'd2,
    HOLD_EMPTY = 2'd3
  } fsm_state_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DIV   = 1;
  localparam int DEF_HOLD  = 0;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_fill_drain_if.sv
// LED output bus between the sequencer (master) and the board pins (slave).
interface led_fill_drain_if
  import led_fill_drain_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic [WIDTH-1:0] Q;

  modport master (output Q);
  modport slave  (input  Q);
endinterface

// File: rtl/led_step_prescaler.sv
// Step-rate prescaler: step_tick pulses once every DIV clocks.
// With DIV=1 the count never leaves zero, so step_tick stays high.
module led_step_prescaler
  import led_fill_drain_pkg::*;
#(
  parameter int DIV = DEF_DIV
) (
  input  logic CLK,
  input  logic RST,
  output logic step_tick
);
  localparam int            CW   = cnt_bits(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_r;

  assign step_tick = (cnt_r == LAST);

  // Free-running 0..DIV-1 counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_r <= '0;
    end else if (step_tick) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end
endmodule

// File: rtl/led_fill_drain.sv
// LED fill-then-drain sequencer: thermometer pattern grows from bit 0,
// optionally dwells at all-ones / all-zeros, then shrinks from the top.
module led_fill_drain
  import led_fill_drain_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV   = DEF_DIV,
  parameter int HOLD  = DEF_HOLD
) (
  input  logic              CLK,
  input  logic              RST,
  led_fill_drain_if.master  bus
);
  localparam logic [1:0] S_FILL       = FILL;
  localparam logic [1:0] S_HOLD_FULL  = HOLD_FULL;
  localparam logic [1:0] S_DRAIN      = DRAIN;
  localparam logic [1:0] S_HOLD_EMPTY = HOLD_EMPTY;

  localparam int               HW        = cnt_bits(HOLD);
  localparam logic [HW-1:0]    HOLD_LAST = HW'((HOLD > 0) ? HOLD - 1 : 0);
  localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ALL_ZERO  = {WIDTH{1'b0}};

  logic             step_tick_s;
  logic [1:0]       state_r, state_nxt_s;
  logic [WIDTH-1:0] q_r, q_nxt_s;
  logic [HW-1:0]    hold_cnt_r, hold_nxt_s;

  led_step_prescaler #(.DIV(DIV)) u_prescaler (
    .CLK       (CLK),
    .RST       (RST),
    .step_tick (step_tick_s)
  );

  // Next-state and next-pattern logic; everything holds between ticks.
  always_comb begin
    state_nxt_s = state_r;
    q_nxt_s     = q_r;
    hold_nxt_s  = hold_cnt_r;
    if (step_tick_s) begin
      case (state_r)
        S_FILL: begin
          q_nxt_s = {q_r[WIDTH-2:0], 1'b1};
          if (q_nxt_s == ALL_ONES) begin
            state_nxt_s = (HOLD > 0) ? S_HOLD_FULL : S_DRAIN;
          end else begin
            state_nxt_s = S_FILL;
          end
        end
        S_HOLD_FULL: begin
          if (hold_cnt_r == HOLD_LAST) begin
            hold_nxt_s  = '0;
            state_nxt_s = S_DRAIN;
          end else begin
            hold_nxt_s  = hold_cnt_r + HW'(1);
          end
        end
        S_DRAIN: begin
          q_nxt_s = {1'b0, q_r[WIDTH-1:1]};
          if (q_nxt_s == ALL_ZERO) begin
            state_nxt_s = (HOLD > 0) ? S_HOLD_EMPTY : S_FILL;
          end else begin
            state_nxt_s = S_DRAIN;
          end
        end
        S_HOLD_EMPTY: begin
          if (hold_cnt_r == HOLD_LAST) begin
            hold_nxt_s  = '0;
            state_nxt_s = S_FILL;
          end else begin
            hold_nxt_s  = hold_cnt_r + HW'(1);
          end
        end
        // Corrupted state: resume filling, pattern untouched.
        default: begin
          state_nxt_s = S_FILL;
          hold_nxt_s  = '0;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State, pattern and dwell counter registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r    <= S_FILL;
      q_r        <= '0;
      hold_cnt_r <= '0;
    end else begin
      state_r    <= state_nxt_s;
      q_r        <= q_nxt_s;
      hold_cnt_r <= hold_nxt_s;
    end
  end

  assign bus.Q = q_r;
endmodule

// File: tb/tb_led_fill_drain.sv
// Bench for led_fill_drain: vector table, directed corner cases and a
// randomized run against a step-indexed reference model.
module tb_led_fill_drain;
  localparam int W = 8;

  logic CLK = 1'b0;
  logic rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;
  int   tests = 0, fails = 0;

  always #5 CLK = ~CLK;

  led_fill_drain_if #(.WIDTH(W)) if0 ();
  led_fill_drain_if #(.WIDTH(W)) if1 ();
  led_fill_drain_if #(.WIDTH(W)) if2 ();

  led_fill_drain #(.WIDTH(W), .DIV(1), .HOLD(0)) u0 (.CLK(CLK), .RST(rst0), .bus(if0));
  led_fill_drain #(.WIDTH(W), .DIV(4), .HOLD(0)) u1 (.CLK(CLK), .RST(rst1), .bus(if1));
  led_fill_drain #(.WIDTH(W), .DIV(1), .HOLD(2)) u2 (.CLK(CLK), .RST(rst2), .bus(if2));

  typedef struct {
    logic       rst;
    logic [7:0] q;
  } vec_t;

  vec_t tbl [18];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Number of lit LEDs after tick number idx+1 of the sequence.
  function automatic int ones_at(input int idx, input int hold);
    int i;
    i = idx;
    if (i < W) return i + 1;
    i -= W;
    if (i < hold) return W;
    i -= hold;
    if (i < W) return W - 1 - i;
    return 0;
  endfunction

  function automatic logic [7:0] therm(input int k);
    return 8'(((1 << k) - 1) & 255);
  endfunction

  initial begin
    int cyc [2];
    int idx [2];
    int ones [2];
    int divs [2];
    int holds [2];
    logic [7:0] prev [2];
    logic [7:0] act;
    logic r;
    logic [7:0] fill_exp [4];
    logic [7:0] empty_exp [4];
    logic [7:0] seq [17];

    seq = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
            8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00, 8'h01};
    tbl[0] = '{rst: 1'b1, q: 8'h00};
    for (int i = 0; i < 17; i++) tbl[i+1] = '{rst: 1'b0, q: seq[i]};

    // Table: reset state then one full cycle plus wrap, DIV=1 HOLD=0.
    for (int i = 0; i < 18; i++) begin
      @(negedge CLK);
      rst0 = tbl[i].rst;
      tick();
      check($sformatf("table_%0d", i), if0.Q, tbl[i].q);
    end

    // Asynchronous reset between edges at Q=3F.
    repeat (5) tick();
    check("pre_async_3F", if0.Q, 8'h3F);
    #2 rst0 = 1'b1;
    #1 check("async_clear", if0.Q, 8'h00);
    #100 check("reset_hold", if0.Q, 8'h00);

    // Reset mid-drain at Q=1F, then filling must restart.
    @(negedge CLK) rst0 = 1'b0;
    repeat (11) tick();
    check("pre_drain_1F", if0.Q, 8'h1F);
    @(negedge CLK) rst0 = 1'b1;
    @(negedge CLK) rst0 = 1'b0;
    tick(); check("post_rst_01", if0.Q, 8'h01);
    tick(); check("post_rst_03", if0.Q, 8'h03);
    tick(); check("post_rst_07", if0.Q, 8'h07);

    // Prescaler DIV=4.
    @(negedge CLK) rst1 = 1'b0;
    for (int e = 1; e <= 32; e++) begin
      tick();
      if (e < 4) check($sformatf("div4_edge%0d", e), if1.Q, 8'h00);
      else if (e == 4) check("div4_edge4", if1.Q, 8'h01);
      else if (e == 8) check("div4_edge8", if1.Q, 8'h03);
      else if (e == 32) check("div4_edge32", if1.Q, 8'hFF);
    end

    // Dwell HOLD=2 at both ends.
    fill_exp  = '{8'hFF, 8'hFF, 8'hFF, 8'h7F};
    empty_exp = '{8'h00, 8'h00, 8'h00, 8'h01};
    @(negedge CLK) rst2 = 1'b0;
    for (int e = 1; e <= 21; e++) begin
      tick();
      if (e >= 8 && e <= 11) check($sformatf("hold_full_e%0d", e), if2.Q, fill_exp[e-8]);
      if (e >= 18) check($sformatf("hold_empty_e%0d", e), if2.Q, empty_exp[e-18]);
    end

    // Randomized resets on u1/u2 against the step model.
    divs  = '{4, 1};
    holds = '{0, 2};
    for (int c = 0; c < 1000; c++) begin
      @(negedge CLK);
      r = (c == 0) || ($urandom_range(0, 49) == 0);
      rst1 = r;
      rst2 = r;
      #1;
      if (r) begin
        for (int i = 0; i < 2; i++) begin
          act = (i == 0) ? if1.Q : if2.Q;
          check($sformatf("rnd_async_u%0d", i + 1), act, 8'h00);
          cyc[i] = 0; idx[i] = 0; ones[i] = 0; prev[i] = 8'h00;
        end
      end
      tick();
      for (int i = 0; i < 2; i++) begin
        act = (i == 0) ? if1.Q : if2.Q;
        if (!r) begin
          if (((cyc[i] + 1) % divs[i]) == 0) begin
            ones[i] = ones_at(idx[i], holds[i]);
            idx[i]  = (idx[i] + 1) % (2 * W + 2 * holds[i]);
            if (!(holds[i] > 0 && act == prev[i]))
              check($sformatf("rnd_onebit_u%0d", i + 1), 8'($countones(act ^ prev[i])), 8'd1);
            prev[i] = act;
          end
          cyc[i]++;
        end
        check($sformatf("rnd_model_u%0d_c%0d", i + 1, c), act, therm(ones[i]));
        check($sformatf("rnd_therm_u%0d", i + 1), act & (act + 8'd1), 8'h00);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
